// File: rtl/key_sw_conditioner_if.sv
// Signal bundle between the raw DE10-Lite switch/key pins, the conditioner and the PIO side.
// Signal names match the board-level pin and PIO naming.
interface key_sw_conditioner_if;
   logic [8:0] SW;
   logic [1:0] KEY;
   logic [1:0] EVT_CLR;
   logic [8:0] SW_DB;
   logic       SW_CHG;
   logic [1:0] KEY_DB;
   logic [1:0] KEY_PRESS;
   logic [1:0] KEY_EVT;

   // Board/PIO side: drives raw inputs and clear strobes, observes conditioned levels.
   modport master (
      output SW, KEY, EVT_CLR,
      input  SW_DB, SW_CHG, KEY_DB, KEY_PRESS, KEY_EVT
   );

   // Conditioner side.
   modport slave (
      input  SW, KEY, EVT_CLR,
      output SW_DB, SW_CHG, KEY_DB, KEY_PRESS, KEY_EVT
   );
endinterface

// File: rtl/key_sw_conditioner.sv
// Synchronises and debounces 9 slide switches and 2 active-low keys; generates press pulses,
// a switch-change pulse and sticky software-clearable key-event flags. All outputs registered.
module key_sw_conditioner #(
   parameter int unsigned DB_CYCLES = 500000,
   parameter int unsigned CW        = $clog2(DB_CYCLES)
) (
   input logic                 CLK,
   input logic                 RST,
   key_sw_conditioner_if.slave bus
);

   localparam int unsigned NumIn = 11;
   localparam logic [CW-1:0] CntLast = CW'(DB_CYCLES - 1);

   logic [NumIn-1:0] raw;
   logic [NumIn-1:0] s1_q, s2_q;
   logic [NumIn-1:0] db_q, db_d;
   logic [CW-1:0]    cnt_q [NumIn];
   logic [CW-1:0]    cnt_d [NumIn];
   logic [1:0]       key_rise;
   logic             sw_change;
   logic             sw_chg_q;
   logic [1:0]       key_press_q, key_evt_q;

   // Keys inverted ahead of the synchroniser so everything downstream is active-high.
   assign raw = {~bus.KEY, bus.SW};

   always_comb begin
      for (int i = 0; i < NumIn; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CntLast) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign key_rise  = db_d[10:9] & ~db_q[10:9];
   assign sw_change = |(db_d[8:0] ^ db_q[8:0]);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_q        <= '0;
         s2_q        <= '0;
         db_q        <= '0;
         sw_chg_q    <= 1'b0;
         key_press_q <= '0;
         key_evt_q   <= '0;
         for (int i = 0; i < NumIn; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q        <= raw;
         s2_q        <= s1_q;
         db_q        <= db_d;
         sw_chg_q    <= sw_change;
         key_press_q <= key_rise;
         // Set takes priority over a coincident clear.
         key_evt_q   <= (key_evt_q & ~bus.EVT_CLR) | key_rise;
         for (int i = 0; i < NumIn; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.SW_DB     = db_q[8:0];
   assign bus.KEY_DB    = db_q[10:9];
   assign bus.SW_CHG    = sw_chg_q;
   assign bus.KEY_PRESS = key_press_q;
   assign bus.KEY_EVT   = key_evt_q;

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DB_CYCLES=4: reset, clean press/release,
// bounce, glitch rejection, set/clear collision and reset in the middle of a window.
module tb_key_sw_conditioner;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   tests  = 0;
   int   failed = 0;

   key_sw_conditioner_if bus ();

   key_sw_conditioner #(.DB_CYCLES(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [15:0] all_outs;
   assign all_outs = {bus.SW_DB, bus.SW_CHG, bus.KEY_DB, bus.KEY_PRESS, bus.KEY_EVT};

   task automatic test_reset();
      bus.KEY     = 2'b00;
      bus.SW      = 9'h1FF;
      bus.EVT_CLR = 2'b00;
      RST         = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         tests++;
         if (all_outs !== 16'h0) begin
            failed++;
            $display("FAIL reset_held cycle %0d: outputs=%h, required 0000", i, all_outs);
         end
         bus.SW = ~bus.SW;
      end
      bus.KEY = 2'b11;
      bus.SW  = 9'h000;
      RST     = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         tests++;
         if (all_outs !== 16'h0) begin
            failed++;
            $display("FAIL reset_release cycle %0d: outputs=%h, required 0000", i, all_outs);
         end
      end
   endtask

   task automatic test_clean_press();
      bus.KEY = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         tests++;
         if ({bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]} !== 3'b000) begin
            failed++;
            $display("FAIL press_early edge %0d: db/press/evt=%b%b%b, required 000", i,
                     bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]);
         end
      end
      @(negedge CLK);
      tests++;
      if ({bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]} !== 3'b111) begin
         failed++;
         $display("FAIL press_rise: db/press/evt=%b%b%b, required 111",
                  bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]);
      end
      @(negedge CLK);
      tests++;
      if ({bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]} !== 3'b101) begin
         failed++;
         $display("FAIL press_one_cycle: db/press/evt=%b%b%b, required 101",
                  bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]);
      end
      bus.KEY = 2'b11;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         tests++;
         if ({bus.KEY_DB[0], bus.KEY_PRESS[0]} !== 2'b10) begin
            failed++;
            $display("FAIL release_early edge %0d: db/press=%b%b, required 10", i,
                     bus.KEY_DB[0], bus.KEY_PRESS[0]);
         end
      end
      @(negedge CLK);
      tests++;
      if ({bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]} !== 3'b001) begin
         failed++;
         $display("FAIL release_fall: db/press/evt=%b%b%b, required 001",
                  bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT[0]);
      end
      bus.EVT_CLR = 2'b01;
      @(negedge CLK);
      bus.EVT_CLR = 2'b00;
      tests++;
      if (bus.KEY_EVT !== 2'b00) begin
         failed++;
         $display("FAIL evt_clear: key_evt=%b, required 00", bus.KEY_EVT);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int i = 0; i < 20; i++) begin
         bus.KEY[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge CLK);
         if (bus.KEY_PRESS[1] === 1'b1 || bus.KEY_DB[1] === 1'b1) pulses++;
      end
      bus.KEY[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (bus.KEY_PRESS[1] === 1'b1 || bus.KEY_DB[1] === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         failed++;
         $display("FAIL bounce_early: early press/db cycles=%0d, required 0", pulses);
      end
      @(negedge CLK);
      tests++;
      if ({bus.KEY_DB[1], bus.KEY_PRESS[1], bus.KEY_EVT[1]} !== 3'b111) begin
         failed++;
         $display("FAIL bounce_rise: db/press/evt=%b%b%b, required 111",
                  bus.KEY_DB[1], bus.KEY_PRESS[1], bus.KEY_EVT[1]);
      end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (bus.KEY_PRESS[1] === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         failed++;
         $display("FAIL bounce_extra_pulse: extra pulses=%0d, required 0", pulses);
      end
      bus.KEY     = 2'b11;
      bus.EVT_CLR = 2'b11;
      @(negedge CLK);
      bus.EVT_CLR = 2'b00;
      repeat (8) @(negedge CLK);
      tests++;
      if ({bus.KEY_DB, bus.KEY_EVT} !== 4'b0000) begin
         failed++;
         $display("FAIL bounce_cleanup: key_db=%b key_evt=%b, required 00/00",
                  bus.KEY_DB, bus.KEY_EVT);
      end
   endtask

   task automatic test_glitch();
      int chg = 0;
      bus.SW[3] = 1'b1;
      repeat (3) @(negedge CLK);
      bus.SW[3] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         tests++;
         if (bus.SW_DB !== 9'h000 || bus.SW_CHG !== 1'b0) begin
            failed++;
            $display("FAIL glitch_reject cycle %0d: sw_db=%h sw_chg=%b, required 000/0", i,
                     bus.SW_DB, bus.SW_CHG);
         end
      end
      bus.SW[3:0] = 4'hA;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (bus.SW_CHG === 1'b1) chg++;
      end
      @(negedge CLK);
      tests++;
      if (bus.SW_DB !== 9'h00A || bus.SW_CHG !== 1'b1) begin
         failed++;
         $display("FAIL sw_update: sw_db=%h sw_chg=%b, required 00a/1", bus.SW_DB, bus.SW_CHG);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (bus.SW_CHG === 1'b1) chg++;
      end
      tests++;
      if (chg != 0) begin
         failed++;
         $display("FAIL sw_chg_single: extra sw_chg cycles=%0d, required 0", chg);
      end
      bus.SW = 9'h000;
      repeat (8) @(negedge CLK);
      tests++;
      if (bus.SW_DB !== 9'h000) begin
         failed++;
         $display("FAIL sw_cleanup: sw_db=%h, required 000", bus.SW_DB);
      end
   endtask

   task automatic test_clear_collision();
      bus.KEY = 2'b10;
      repeat (5) @(negedge CLK);
      bus.EVT_CLR = 2'b01;
      @(negedge CLK);
      bus.EVT_CLR = 2'b00;
      tests++;
      if ({bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT} !== 4'b1101) begin
         failed++;
         $display("FAIL collision_set_wins: db/press=%b%b key_evt=%b, required 11/01",
                  bus.KEY_DB[0], bus.KEY_PRESS[0], bus.KEY_EVT);
      end
      repeat (9) @(negedge CLK);
      tests++;
      if (bus.KEY_EVT !== 2'b01) begin
         failed++;
         $display("FAIL evt_sticky: key_evt=%b, required 01", bus.KEY_EVT);
      end
      bus.EVT_CLR = 2'b01;
      @(negedge CLK);
      bus.EVT_CLR = 2'b00;
      tests++;
      if (bus.KEY_EVT !== 2'b00 || bus.KEY_DB[0] !== 1'b1) begin
         failed++;
         $display("FAIL collision_clear: key_evt=%b key_db0=%b, required 00/1",
                  bus.KEY_EVT, bus.KEY_DB[0]);
      end
      bus.KEY = 2'b11;
      repeat (8) @(negedge CLK);
   endtask

   task automatic test_reset_mid_count();
      bus.KEY = 2'b10;
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      #1;
      tests++;
      if (all_outs !== 16'h0) begin
         failed++;
         $display("FAIL midreset_async: outputs=%h, required 0000", all_outs);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         tests++;
         if (all_outs !== 16'h0) begin
            failed++;
            $display("FAIL midreset_early edge %0d: outputs=%h, required 0000", i, all_outs);
         end
      end
      @(negedge CLK);
      tests++;
      if ({bus.KEY_DB, bus.KEY_PRESS, bus.KEY_EVT} !== 6'b01_01_01) begin
         failed++;
         $display("FAIL midreset_press: key_db=%b key_press=%b key_evt=%b, required 01/01/01",
                  bus.KEY_DB, bus.KEY_PRESS, bus.KEY_EVT);
      end
      @(negedge CLK);
      tests++;
      if (bus.KEY_PRESS !== 2'b00) begin
         failed++;
         $display("FAIL midreset_pulse_width: key_press=%b, required 00", bus.KEY_PRESS);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_clear_collision();
      test_reset_mid_count();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
